// File: rtl/vram_arbiter_pkg.sv
// Shared types and helpers for the VRAM arbiter.
//   req_id_t     : requester index (display, physics, paint)
//   lock_state_t : physics lock FSM states
//   N_REQ        : number of requesters
//   pixel_count  : number of legal pixel addresses in a frame
package vram_arbiter_pkg;

  localparam int unsigned N_REQ = 3;

  typedef enum logic [1:0] {
    REQ_DISPLAY = 2'd0,
    REQ_PHYSICS = 2'd1,
    REQ_PAINT   = 2'd2
  } req_id_t;

  typedef enum logic [1:0] {
    UNLOCKED,
    LOCKED,
    EXPIRED
  } lock_state_t;

  function automatic int unsigned pixel_count(input int unsigned cols, input int unsigned rows);
    return cols * rows;
  endfunction

endpackage

// File: rtl/vram_arbiter_rr_pick2.sv
// Two-way round-robin pick between physics and paint.
//   clk, reset : clock and synchronous active-high reset
//   req        : [0] physics request, [1] paint request
//   xfer       : [0] physics transfer, [1] paint transfer (actual accepts from the top)
//   pick       : one-hot pick; zero when neither requests
// The pointer moves on real transfers only, so a physics transfer taken under
// the lock still hands preference to paint afterwards.
module rr_pick2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] xfer,
  output logic [1:0] pick
);

  logic ptr_q;  // 0: physics preferred, 1: paint preferred

  always_comb begin
    pick = 2'b00;
    if (req[0] && req[1]) begin
      pick = ptr_q ? 2'b10 : 2'b01;
    end else if (req[0]) begin
      pick = 2'b01;
    end else if (req[1]) begin
      pick = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (xfer[0]) begin
      ptr_q <= 1'b1;
    end else if (xfer[1]) begin
      ptr_q <= 1'b0;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter for display fetch, sand physics and user paint.
//   clk_i, reset_i     : clock, synchronous active-high reset
//   req_i/we_i         : per-requester request and write enable (bit k = requester k)
//   addr_i/wdata_i     : per-requester address/data, requester k at slice k
//   gnt_o              : combinational one-hot grant
//   rdata_o/rvalid_o   : shared read-return bus and one-hot owner strobe
//   lock_i             : physics exclusivity request
//   lock_err_o         : sticky, lock held past LOCK_MAX_CYCLES
//   addr_err_o         : one-cycle pulse after an out-of-range transfer
//   ram_addr_o/ram_we_o/ram_wdata_o/ram_rdata_i : synchronous VRAM port
// Display always wins; physics and paint share the rest round-robin, with
// paint locked out while physics holds a bounded lock.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned VRAM_ADDR_WIDTH = 19,
  parameter int unsigned VRAM_DATA_WIDTH = 1,
  parameter int unsigned ACTIVE_COLUMNS  = 640,
  parameter int unsigned ACTIVE_ROWS     = 480,
  parameter int unsigned LOCK_MAX_CYCLES = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [N_REQ-1:0]                   req_i,
  input  logic [N_REQ-1:0]                   we_i,
  input  logic [N_REQ*VRAM_ADDR_WIDTH-1:0]   addr_i,
  input  logic [N_REQ*VRAM_DATA_WIDTH-1:0]   wdata_i,
  output logic [N_REQ-1:0]                   gnt_o,
  output logic [VRAM_DATA_WIDTH-1:0]         rdata_o,
  output logic [N_REQ-1:0]                   rvalid_o,
  input  logic                               lock_i,
  output logic                               lock_err_o,
  output logic                               addr_err_o,
  output logic [VRAM_ADDR_WIDTH-1:0]         ram_addr_o,
  output logic                               ram_we_o,
  output logic [VRAM_DATA_WIDTH-1:0]         ram_wdata_o,
  input  logic [VRAM_DATA_WIDTH-1:0]         ram_rdata_i
);

  localparam int unsigned PixelCount = pixel_count(ACTIVE_COLUMNS, ACTIVE_ROWS);
  localparam logic [VRAM_ADDR_WIDTH:0] PixelLimit = PixelCount[VRAM_ADDR_WIDTH:0];
  localparam int unsigned CntWidth = $clog2(LOCK_MAX_CYCLES + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(LOCK_MAX_CYCLES - 1);

  lock_state_t                 lock_state_q;
  logic [CntWidth-1:0]         lock_cnt_q;
  logic                        lock_err_q;

  logic [N_REQ-1:0]            gnt;
  logic [N_REQ-1:0]            xfer;
  logic [1:0]                  rr_pick;

  logic [VRAM_ADDR_WIDTH-1:0]  sel_addr;
  logic                        sel_we;
  logic [VRAM_DATA_WIDTH-1:0]  sel_wdata;
  logic                        sel_oor;

  logic [VRAM_ADDR_WIDTH-1:0]  ram_addr_q;
  logic                        ram_we_q;
  logic [VRAM_DATA_WIDTH-1:0]  ram_wdata_q;
  logic                        addr_err_q;

  // Read-return pipeline: owner id and out-of-range flag per stage.
  logic [N_REQ-1:0]            rd_stage1_q, rd_stage2_q;
  logic                        oor_stage1_q, oor_stage2_q;

  rr_pick2 u_rr_pick2 (
    .clk   (clk_i),
    .reset (reset_i),
    .req   (req_i[REQ_PAINT:REQ_PHYSICS]),
    .xfer  (xfer[REQ_PAINT:REQ_PHYSICS]),
    .pick  (rr_pick)
  );

  always_comb begin
    gnt = '0;
    if (!reset_i) begin
      if (req_i[REQ_DISPLAY]) begin
        gnt[REQ_DISPLAY] = 1'b1;
      end else if (lock_state_q == LOCKED) begin
        gnt[REQ_PHYSICS] = req_i[REQ_PHYSICS];
      end else begin
        gnt[REQ_PAINT:REQ_PHYSICS] = rr_pick;
      end
    end
  end

  assign xfer  = req_i & gnt;
  assign gnt_o = gnt;

  always_comb begin
    sel_addr  = addr_i[0 +: VRAM_ADDR_WIDTH];
    sel_we    = we_i[0];
    sel_wdata = wdata_i[0 +: VRAM_DATA_WIDTH];
    for (int unsigned k = 1; k < N_REQ; k++) begin
      if (gnt[k]) begin
        sel_addr  = addr_i[k*VRAM_ADDR_WIDTH +: VRAM_ADDR_WIDTH];
        sel_we    = we_i[k];
        sel_wdata = wdata_i[k*VRAM_DATA_WIDTH +: VRAM_DATA_WIDTH];
      end
    end
  end

  assign sel_oor = {1'b0, sel_addr} >= PixelLimit;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      addr_err_q   <= 1'b0;
      rd_stage1_q  <= '0;
      rd_stage2_q  <= '0;
      oor_stage1_q <= 1'b0;
      oor_stage2_q <= 1'b0;
    end else begin
      ram_we_q     <= 1'b0;
      addr_err_q   <= 1'b0;
      rd_stage1_q  <= '0;
      oor_stage1_q <= 1'b0;
      if (|xfer) begin
        ram_addr_q  <= sel_addr;
        ram_wdata_q <= sel_wdata;
        // Out-of-range accesses are accepted but never reach the array.
        ram_we_q    <= sel_we & ~sel_oor;
        addr_err_q  <= sel_oor;
        if (!sel_we) begin
          rd_stage1_q  <= xfer;
          oor_stage1_q <= sel_oor;
        end
      end
      rd_stage2_q  <= rd_stage1_q;
      oor_stage2_q <= oor_stage1_q;
    end
  end

  // Lock FSM: lock_cnt runs every locked cycle, display grants included.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_state_q <= UNLOCKED;
      lock_cnt_q   <= '0;
      lock_err_q   <= 1'b0;
    end else begin
      unique case (lock_state_q)
        UNLOCKED: begin
          if (lock_i && xfer[REQ_PHYSICS]) begin
            lock_state_q <= LOCKED;
            lock_cnt_q   <= '0;
          end
        end
        LOCKED: begin
          if (!lock_i) begin
            lock_state_q <= UNLOCKED;
          end else if (lock_cnt_q == CntLast) begin
            lock_state_q <= EXPIRED;
            lock_err_q   <= 1'b1;
          end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
        EXPIRED: begin
          if (!lock_i) begin
            lock_state_q <= UNLOCKED;
          end
        end
        default: lock_state_q <= UNLOCKED;
      endcase
    end
  end

  assign ram_addr_o  = ram_addr_q;
  assign ram_we_o    = ram_we_q;
  assign ram_wdata_o = ram_wdata_q;
  assign addr_err_o  = addr_err_q;
  assign lock_err_o  = lock_err_q;
  assign rvalid_o    = rd_stage2_q;
  // The RAM data lines up with stage 2; out-of-range reads return zero.
  assign rdata_o     = (|rd_stage2_q && !oor_stage2_q) ? ram_rdata_i : '0;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port 1-bit-per-pixel VRAM between three requesters: VGA display fetch, sand physics engine, and user paint writer.
- Sits between those three blocks and the VRAM instance inside falling_sand_game_top.
- Display has strict priority. Physics and paint share the remaining slots round-robin.
- Physics may take a bounded lock for read-modify-write of cell pairs; paint is held off while the lock is active.

Parameters:
- VRAM_ADDR_WIDTH, 19, VRAM address width.
- VRAM_DATA_WIDTH, 1, bits per pixel.
- ACTIVE_COLUMNS, 640, frame width in pixels.
- ACTIVE_ROWS, 480, frame height; legal addresses are 0 .. ACTIVE_COLUMNS*ACTIVE_ROWS-1 (0..307199).
- LOCK_MAX_CYCLES, 16, maximum consecutive cycles physics lock is honoured.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous active-high reset
- req_i  in  3  request per requester; bit 0 = display, bit 1 = physics, bit 2 = paint
- we_i  in  3  write enable per requester
- addr_i  in  3*VRAM_ADDR_WIDTH  address per requester, packed with requester k at slice k
- wdata_i  in  3*VRAM_DATA_WIDTH  write data per requester, packed with requester k at slice k
- gnt_o  out  3  combinational one-hot grant
- rdata_o  out  VRAM_DATA_WIDTH  shared read-return bus
- rvalid_o  out  3  one-hot read-return strobe, identifies the owner of rdata_o
- lock_i  in  1  physics exclusivity request
- lock_err_o  out  1  sticky flag: lock exceeded LOCK_MAX_CYCLES
- addr_err_o  out  1  one-cycle pulse: accepted access was out of range
- ram_addr_o  out  VRAM_ADDR_WIDTH  VRAM address
- ram_we_o  out  1  VRAM write enable
- ram_wdata_o  out  VRAM_DATA_WIDTH  VRAM write data
- ram_rdata_i  in  VRAM_DATA_WIDTH  VRAM read data (synchronous RAM, 1-cycle latency)

Behaviour:
- Handshake:
  - A transfer occurs at the clk_i edge where req_i[k] && gnt_o[k].
  - A requester holds req, we, addr and wdata stable until its transfer.
  - At most one gnt_o bit is high per cycle.
  - A requester may keep req_i high across cycles to issue back-to-back transfers.
- Grant selection (combinational, from req_i and registered state):
  - req_i[0] set: display wins.
  - Otherwise, if lock is in state LOCKED: physics wins if requesting; paint gets no grant.
  - Otherwise physics/paint round-robin. rr_ptr names the preferred requester; if only one of the two requests, it wins.
  - rr_ptr updates only on a physics or paint transfer, to point at the other requester.
  - rr_ptr resets to physics.
- RAM issue: at the transfer edge, ram_addr_o, ram_we_o and ram_wdata_o are registered from the winner. With no transfer, ram_we_o is 0 and ram_addr_o holds its value.
- Read return:
  - A read accepted at edge E0 produces rvalid_o[k]=1 with rdata_o=ram_rdata_i during the cycle after edge E0+1 (2-cycle latency, pipelined at one read per cycle).
  - rvalid_o is a 2-stage registered shift of the owner id.
- Range check: if addr >= ACTIVE_COLUMNS*ACTIVE_ROWS, the access is still granted, and:
  - ram_we_o is forced to 0;
  - a read returns rdata_o = 0 with the normal rvalid_o timing;
  - addr_err_o pulses in the cycle after the transfer.
- Lock FSM, states UNLOCKED, LOCKED, EXPIRED:
  - UNLOCKED -> LOCKED when lock_i=1 and physics transfers. lock_cnt is cleared.
  - LOCKED: lock_cnt increments every cycle.
  - LOCKED -> UNLOCKED when lock_i=0.
  - LOCKED -> EXPIRED when lock_cnt reaches LOCK_MAX_CYCLES-1 with lock_i still 1; lock_err_o is set (sticky until reset).
  - EXPIRED behaves as UNLOCKED for arbitration.
  - EXPIRED -> UNLOCKED when lock_i=0.
  - Display preempts in every state; display grants do not pause lock_cnt.
- Reset (synchronous): all registered outputs 0, rvalid pipeline cleared, rr_ptr=physics, FSM=UNLOCKED, lock_cnt=0, lock_err_o=0.
  - gnt_o is 0 in any cycle where reset_i=1.
  - A read in flight when reset is asserted returns no rvalid.
- Simultaneous events: a lock_i rise in a cycle where paint already holds the grant does not revoke it. The lock begins only on the next physics transfer.

Decomposition:
- Package vram_arbiter_pkg:
  - req_id_t enum: REQ_DISPLAY=0, REQ_PHYSICS=1, REQ_PAINT=2.
  - lock_state_t enum: UNLOCKED, LOCKED, EXPIRED.
  - Constant N_REQ=3.
  - Function pixel_count(cols, rows).
- Sub-module rr_pick2: two-way round-robin pick, with rr_ptr register and update-on-accept. Instantiated once.

Test Plan:
- Reset, then all three req_i high with all reads: gnt_o=001 each cycle while display requests. Drop display: grants alternate 010,100,010...
- Physics write addr 100 data 1, then physics read addr 100: ram_we_o=1 at edge+1; read returns rvalid_o=010, rdata_o=1 exactly 2 cycles after its transfer.
- lock_i=1 with physics and paint continuously requesting: paint gets gnt=0 for 16 cycles. Expiry then sets lock_err_o=1 and the round-robin resumes; lock_i=0 returns the FSM to UNLOCKED.
- Paint write addr 307200: granted, ram_we_o=0, addr_err_o pulses once. Read addr 307199 proceeds normally with no error.
- Back-to-back display reads addr 0..3: four consecutive transfers, then rvalid_o=001 for 4 consecutive cycles starting 2 cycles after the first transfer.
- reset_i asserted one cycle after a read transfer: no rvalid_o pulse follows, and all outputs read 0 on the next cycle.
